// File: rtl/iic_txn_pkg.sv
// Shared constants for the AXI IIC transaction engine: register map, TX_FIFO
// command flags, status-register bit positions and FSM state encodings.
package iic_txn_pkg;

  localparam logic [11:0] REG_SOFTR   = 12'h040;
  localparam logic [11:0] REG_CR      = 12'h100;
  localparam logic [11:0] REG_SR      = 12'h104;
  localparam logic [11:0] REG_TX_FIFO = 12'h108;
  localparam logic [11:0] REG_RX_FIFO = 12'h10C;

  localparam logic [9:0]  TX_START    = 10'h100;
  localparam logic [9:0]  TX_STOP     = 10'h200;
  localparam logic [31:0] SOFTR_KEY   = 32'h0000_000A;
  localparam logic [31:0] CR_ENABLE   = 32'h0000_0001;

  localparam int SR_BUS_BUSY = 2;
  localparam int SR_RX_EMPTY = 6;
  localparam int SR_TX_EMPTY = 7;

  typedef logic [3:0] state_t;

  localparam state_t S_INIT_RST = 4'd0;
  localparam state_t S_INIT_CR  = 4'd1;
  localparam state_t S_IDLE     = 4'd2;
  localparam state_t S_START    = 4'd3;
  localparam state_t S_REG      = 4'd4;
  localparam state_t S_WDATA    = 4'd5;
  localparam state_t S_RSTART   = 4'd6;
  localparam state_t S_RCNT     = 4'd7;
  localparam state_t S_POLL     = 4'd8;
  localparam state_t S_RXRD     = 4'd9;
  localparam state_t S_DONE     = 4'd10;
  localparam state_t S_ERR      = 4'd11;

  // Address byte as it goes on the wire: 7-bit device id followed by R/W.
  function automatic logic [9:0] addr_byte(input logic [6:0] dev, input logic rd);
    return {2'b00, dev, rd};
  endfunction

endpackage

// File: rtl/iic_axi_issue.sv
// Single-outstanding AXI access issuer: fires a one-cycle request pulse when the
// FSM asks for an access, then waits for the downstream ack and reports done.
module iic_axi_issue #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          go_i,
  input  logic          rd_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic          done_o,
  output logic [DW-1:0] rdata_o,
  output logic          axi_wr_req_o,
  output logic          axi_rd_req_o,
  output logic [AW-1:0] axi_addr_o,
  output logic [DW-1:0] axi_wdata_o,
  input  logic          axi_ack_i,
  input  logic [DW-1:0] axi_rdata_i
);

  logic busy_q, busy_d;
  logic launch;

  // Handshake: a request is a single-cycle pulse; busy_q stays high until the
  // matching ack, and acks seen while not busy are ignored.
  assign launch       = rst_ni && go_i && !busy_q;
  assign axi_wr_req_o = launch && !rd_i;
  assign axi_rd_req_o = launch && rd_i;
  assign axi_addr_o   = launch ? addr_i : '0;
  assign axi_wdata_o  = (launch && !rd_i) ? wdata_i : '0;
  assign done_o       = busy_q && axi_ack_i;
  assign rdata_o      = axi_rdata_i;

  always_comb begin
    busy_d = busy_q;
    if (launch)      busy_d = 1'b1;
    else if (done_o) busy_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) busy_q <= 1'b0;
    else         busy_q <= busy_d;
  end

endmodule

// File: rtl/iic_txn_engine.sv
// Turns single-byte I2C register reads/writes into the AXI IIC dynamic-mode
// register sequence, including controller init, status polling and timeout.
module iic_txn_engine
  import iic_txn_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 9,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int POLL_LIMIT     = 4096
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic                        seq_req,
  input  logic                        seq_op,
  input  logic [7:0]                  seq_dev_id,
  input  logic [7:0]                  seq_addr,
  input  logic [7:0]                  seq_wdata,
  output logic                        seq_ack,
  output logic [7:0]                  seq_rdata,
  output logic                        seq_err,
  output logic                        ready,
  output logic                        seq_axi_wr_req,
  output logic                        seq_axi_rd_req,
  output logic [AXI_ADDR_WIDTH-1:0]   seq_axi_addr,
  output logic [AXI_DATA_WIDTH-1:0]   seq_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] seq_axi_wstrb,
  input  logic                        seq_axi_ack,
  input  logic [AXI_DATA_WIDTH-1:0]   seq_axi_rdata,
  output state_t                      dbg_state_o
);

  localparam int PCW = $clog2(POLL_LIMIT) + 1;
  localparam logic [PCW-1:0] POLL_MAX = '1;
  localparam logic [PCW-1:0] POLL_LIM = PCW'(POLL_LIMIT);

  state_t state_q, state_d;
  logic              op_q, op_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_q, reg_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic [PCW-1:0]    poll_q, poll_d;

  logic                      acc_go, acc_rd, acc_done, poll_ok;
  logic [AXI_ADDR_WIDTH-1:0] acc_addr;
  logic [AXI_DATA_WIDTH-1:0] acc_data, acc_rdata;
  logic                      unused_bits;

  assign unused_bits = ^{seq_dev_id[7], acc_rdata};

  always_comb begin
    acc_go   = 1'b1;
    acc_rd   = 1'b0;
    acc_addr = AXI_ADDR_WIDTH'(REG_TX_FIFO);
    acc_data = '0;
    case (state_q)
      S_INIT_RST: begin acc_addr = AXI_ADDR_WIDTH'(REG_SOFTR); acc_data = AXI_DATA_WIDTH'(SOFTR_KEY); end
      S_INIT_CR:  begin acc_addr = AXI_ADDR_WIDTH'(REG_CR);    acc_data = AXI_DATA_WIDTH'(CR_ENABLE); end
      S_START:    acc_data = AXI_DATA_WIDTH'(TX_START | addr_byte(dev_q, 1'b0));
      S_REG:      acc_data = AXI_DATA_WIDTH'(reg_q);
      S_WDATA:    acc_data = AXI_DATA_WIDTH'(TX_STOP | {2'b00, wdata_q});
      S_RSTART:   acc_data = AXI_DATA_WIDTH'(TX_START | addr_byte(dev_q, 1'b1));
      S_RCNT:     acc_data = AXI_DATA_WIDTH'(TX_STOP | 10'h001);
      S_POLL:     begin acc_rd = 1'b1; acc_addr = AXI_ADDR_WIDTH'(REG_SR); end
      S_RXRD:     begin acc_rd = 1'b1; acc_addr = AXI_ADDR_WIDTH'(REG_RX_FIFO); end
      default:    acc_go = 1'b0;
    endcase
  end

  // Writes finish once the TX FIFO drained and the bus released; reads once a byte landed.
  assign poll_ok = op_q ? !acc_rdata[SR_RX_EMPTY]
                        : (acc_rdata[SR_TX_EMPTY] && !acc_rdata[SR_BUS_BUSY]);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    poll_d  = poll_q;
    case (state_q)
      S_INIT_RST: if (acc_done) state_d = S_INIT_CR;
      S_INIT_CR:  if (acc_done) state_d = S_IDLE;
      S_IDLE: if (seq_req) begin
        op_d    = seq_op;
        dev_d   = seq_dev_id[6:0];
        reg_d   = seq_addr;
        wdata_d = seq_wdata;
        poll_d  = '0;
        state_d = S_START;
      end
      S_START:  if (acc_done) state_d = S_REG;
      S_REG:    if (acc_done) state_d = op_q ? S_RSTART : S_WDATA;
      S_WDATA:  if (acc_done) state_d = S_POLL;
      S_RSTART: if (acc_done) state_d = S_RCNT;
      S_RCNT:   if (acc_done) state_d = S_POLL;
      S_POLL: if (acc_done) begin
        poll_d = (poll_q == POLL_MAX) ? poll_q : poll_q + PCW'(1);
        if (poll_ok) begin
          state_d = op_q ? S_RXRD : S_DONE;
        end else if (poll_d >= POLL_LIM) begin
          state_d = S_ERR;
          rdata_d = '0;
        end
      end
      S_RXRD: if (acc_done) begin
        rdata_d = acc_rdata[7:0];
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_INIT_RST;
      default: state_d = S_INIT_RST;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= S_INIT_RST;
      op_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      poll_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      poll_q  <= poll_d;
    end
  end

  iic_axi_issue #(
    .AW (AXI_ADDR_WIDTH),
    .DW (AXI_DATA_WIDTH)
  ) u_issue (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .go_i         (acc_go),
    .rd_i         (acc_rd),
    .addr_i       (acc_addr),
    .wdata_i      (acc_data),
    .done_o       (acc_done),
    .rdata_o      (acc_rdata),
    .axi_wr_req_o (seq_axi_wr_req),
    .axi_rd_req_o (seq_axi_rd_req),
    .axi_addr_o   (seq_axi_addr),
    .axi_wdata_o  (seq_axi_wdata),
    .axi_ack_i    (seq_axi_ack),
    .axi_rdata_i  (seq_axi_rdata)
  );

  assign seq_ack       = (state_q == S_DONE) || (state_q == S_ERR);
  assign seq_err       = (state_q == S_ERR);
  assign seq_rdata     = rdata_q;
  assign ready         = (state_q == S_IDLE);
  assign seq_axi_wstrb = '1;
  assign dbg_state_o   = state_q;

endmodule
